conv_seq_engine: RTL and testbench

Sequential, parametrised 2-D multi-channel convolution engine for the CNN accelerator datapath. It computes one output feature map (sum over all input channels of a KxK convolution) with zero padding and configurable stride, using a single multiply-accumulate (MAC) unit. It reads the input and kernel from external single-port memories with 1-cycle read latency and streams results out over a valid/ready interface. It sits between the feature-map SRAM and the next layer's input buffer.

---
 rtl/conv_seq_engine_if.sv | 29 ++
 rtl/conv_seq_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_conv_seq_engine.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_engine_if.sv
// Result stream from the convolution engine to the next layer's
// input buffer: one word per output position, valid/ready handshake.
interface conv_seq_engine_if #(
    parameter int DATA_W = 16,
    parameter int RW     = 4,
    parameter int CW     = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RW-1:0]     out_row;
    logic [CW-1:0]     out_col;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        output out_ready
    );
endinterface

// File: rtl/conv_seq_engine.sv
// Sequential multi-channel 2-D convolution with a single MAC unit.
// One tap per cycle, zero padding, stride, shift/ReLU/saturate on output.
module conv_seq_engine #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int IN_H   = 13,
    parameter int IN_W   = 13,
    parameter int CH     = 256,
    parameter int K      = 3,
    parameter int PAD    = 1,
    parameter int STRIDE = 1,
    localparam int OUT_H = (IN_H + 2*PAD - K)/STRIDE + 1,
    localparam int OUT_W = (IN_W + 2*PAD - K)/STRIDE + 1,
    localparam int IRW   = (IN_H  > 1) ? $clog2(IN_H)  : 1,
    localparam int ICW   = (IN_W  > 1) ? $clog2(IN_W)  : 1,
    localparam int CHW   = (CH    > 1) ? $clog2(CH)    : 1,
    localparam int KW    = (K     > 1) ? $clog2(K)     : 1,
    localparam int ORW   = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_relu,
    input  logic [5:0]        cfg_shift,
    output logic              busy,
    output logic              done,
    output logic              in_rd_en,
    output logic [IRW-1:0]    in_row,
    output logic [ICW-1:0]    in_col,
    output logic [CHW-1:0]    in_ch,
    input  logic [DATA_W-1:0] in_data,
    output logic              k_rd_en,
    output logic [KW-1:0]     k_m,
    output logic [KW-1:0]     k_n,
    output logic [CHW-1:0]    k_ch,
    input  logic [DATA_W-1:0] k_data,
    conv_seq_engine_if.master out_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } st_e;

    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    st_e st_q, st_d;

    logic [ORW-1:0] row_q, row_d;
    logic [OCW-1:0] col_q, col_d;
    logic [CHW-1:0] c_q, c_d;
    logic [KW-1:0]  m_q, m_d;
    logic [KW-1:0]  n_q, n_d;

    logic       relu_q, relu_d;
    logic [5:0] sh_q, sh_d;

    logic iss_q, iss_d;
    logic first_q, first_d;
    logic inb_q, inb_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]       res_q, res_d;

    int   pi, pj;
    logic inb;
    logic last_tap;
    logic last_pos;
    logic run;

    logic signed [2*DATA_W-1:0] prod;

    function automatic logic [DATA_W-1:0] post_proc(
        input logic signed [ACC_W-1:0] a,
        input logic [5:0]              sh,
        input logic                    relu
    );
        logic signed [ACC_W-1:0] r;
        r = a >>> sh;
        if (relu && r < 0) r = '0;
        if (r > MAXV)      r = MAXV;
        else if (r < MINV) r = MINV;
        return r[DATA_W-1:0];
    endfunction

    always_comb begin
        pi  = int'(row_q)*STRIDE + int'(m_q) - PAD;
        pj  = int'(col_q)*STRIDE + int'(n_q) - PAD;
        inb = (pi >= 0) && (pi < IN_H) &&
              (pj >= 0) && (pj < IN_W);
        last_tap = (c_q == CHW'(CH-1)) &&
                   (m_q == KW'(K-1)) &&
                   (n_q == KW'(K-1));
        last_pos = (row_q == ORW'(OUT_H-1)) &&
                   (col_q == OCW'(OUT_W-1));
        run = (st_q == S_RUN);
    end

    // Padding taps leave strobes and addresses at zero.
    always_comb begin
        in_rd_en = run && inb;
        k_rd_en  = in_rd_en;
        in_row   = in_rd_en ? IRW'(pi) : '0;
        in_col   = in_rd_en ? ICW'(pj) : '0;
        in_ch    = in_rd_en ? c_q : '0;
        k_m      = in_rd_en ? m_q : '0;
        k_n      = in_rd_en ? n_q : '0;
        k_ch     = in_rd_en ? c_q : '0;
    end

    assign prod = $signed(in_data) * $signed(k_data);

    // Read data lands one cycle after the tap, so the MAC runs a cycle behind.
    always_comb begin
        acc_d = acc_q;
        if (iss_q) begin
            acc_d = (first_q ? '0 : acc_q) +
                    (inb_q ? {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod}
                           : '0);
        end
    end

    always_comb begin
        st_d    = st_q;
        row_d   = row_q;
        col_d   = col_q;
        c_d     = c_q;
        m_d     = m_q;
        n_d     = n_q;
        relu_d  = relu_q;
        sh_d    = sh_q;
        iss_d   = 1'b0;
        first_d = 1'b0;
        inb_d   = 1'b0;
        res_d   = res_q;
        unique case (st_q)
            S_IDLE: begin
                if (start) begin
                    st_d   = S_RUN;
                    relu_d = cfg_relu;
                    sh_d   = cfg_shift;
                    row_d  = '0;
                    col_d  = '0;
                    c_d    = '0;
                    m_d    = '0;
                    n_d    = '0;
                end
            end
            S_RUN: begin
                iss_d   = 1'b1;
                inb_d   = inb;
                first_d = (c_q == '0) && (m_q == '0) && (n_q == '0);
                if (n_q == KW'(K-1)) begin
                    n_d = '0;
                    if (m_q == KW'(K-1)) begin
                        m_d = '0;
                        if (c_q == CHW'(CH-1)) c_d = '0;
                        else                   c_d = c_q + 1'b1;
                    end else begin
                        m_d = m_q + 1'b1;
                    end
                end else begin
                    n_d = n_q + 1'b1;
                end
                if (last_tap) st_d = S_DRAIN;
            end
            S_DRAIN: begin
                res_d = post_proc(acc_d, sh_q, relu_q);
                st_d  = S_OUT;
            end
            S_OUT: begin
                if (out_if.out_ready) begin
                    if (last_pos) begin
                        st_d  = S_DONE;
                        row_d = '0;
                        col_d = '0;
                    end else begin
                        st_d = S_RUN;
                        if (col_q == OCW'(OUT_W-1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            c_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            relu_q  <= 1'b0;
            sh_q    <= '0;
            iss_q   <= 1'b0;
            first_q <= 1'b0;
            inb_q   <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            st_q    <= st_d;
            row_q   <= row_d;
            col_q   <= col_d;
            c_q     <= c_d;
            m_q     <= m_d;
            n_q     <= n_d;
            relu_q  <= relu_d;
            sh_q    <= sh_d;
            iss_q   <= iss_d;
            first_q <= first_d;
            inb_q   <= inb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign busy             = (st_q == S_RUN) || (st_q == S_DRAIN) ||
                              (st_q == S_OUT);
    assign done             = (st_q == S_DONE);
    assign out_if.out_valid = (st_q == S_OUT);
    assign out_if.out_data  = res_q;
    assign out_if.out_row   = row_q;
    assign out_if.out_col   = col_q;

endmodule

// File: tb/tb_conv_seq_engine.sv
// Scoreboard bench for conv_seq_engine on a 4x4x2 input, 3x3 kernel.
// Covers raster results, timing, backpressure, saturation, abort, stride.
module tb_conv_seq_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic       s_start = 1'b0;
    logic       relu = 1'b0;
    logic [5:0] shift = '0;

    logic        busy, done, in_rd_en, k_rd_en;
    logic [1:0]  in_row, in_col, k_m, k_n;
    logic [0:0]  in_ch, k_ch;
    logic [15:0] in_data = '0;
    logic [15:0] k_data = '0;

    logic        s_busy, s_done, s_in_rd_en, s_k_rd_en;
    logic [1:0]  s_in_row, s_in_col, s_k_m, s_k_n;
    logic [0:0]  s_in_ch, s_k_ch;
    logic [15:0] s_in_data = '0;
    logic [15:0] s_k_data = '0;

    conv_seq_engine_if #(.DATA_W(16), .RW(2), .CW(2)) oi ();
    conv_seq_engine_if #(.DATA_W(16), .RW(1), .CW(1)) so ();

    conv_seq_engine #(
        .DATA_W(16), .ACC_W(40), .IN_H(4), .IN_W(4),
        .CH(2), .K(3), .PAD(1), .STRIDE(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_relu(relu), .cfg_shift(shift),
        .busy(busy), .done(done),
        .in_rd_en(in_rd_en), .in_row(in_row), .in_col(in_col),
        .in_ch(in_ch), .in_data(in_data),
        .k_rd_en(k_rd_en), .k_m(k_m), .k_n(k_n),
        .k_ch(k_ch), .k_data(k_data),
        .out_if(oi)
    );

    conv_seq_engine #(
        .DATA_W(16), .ACC_W(40), .IN_H(4), .IN_W(4),
        .CH(2), .K(3), .PAD(0), .STRIDE(2)
    ) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .cfg_relu(relu), .cfg_shift(shift),
        .busy(s_busy), .done(s_done),
        .in_rd_en(s_in_rd_en), .in_row(s_in_row), .in_col(s_in_col),
        .in_ch(s_in_ch), .in_data(s_in_data),
        .k_rd_en(s_k_rd_en), .k_m(s_k_m), .k_n(s_k_n),
        .k_ch(s_k_ch), .k_data(s_k_data),
        .out_if(so)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int          mode = 0;
    logic [15:0] in_c = 16'd1;
    logic [15:0] k_c = 16'd1;

    function automatic logic [15:0] in_f(int r, int c, int ch);
        if (mode == 0) return in_c;
        return 16'((((r*7 + c*3 + ch*5) % 11) - 5) * 3000);
    endfunction

    function automatic logic [15:0] k_f(int m, int n, int ch);
        if (mode == 0) return k_c;
        return 16'((((m*5 + n*3 + ch*2) % 7) - 3) * 1000);
    endfunction

    always @(posedge clk) begin
        if (in_rd_en)
            in_data <= in_f(int'(in_row), int'(in_col), int'(in_ch));
        if (k_rd_en)
            k_data <= k_f(int'(k_m), int'(k_n), int'(k_ch));
        if (s_in_rd_en)
            s_in_data <= in_f(int'(s_in_row), int'(s_in_col), int'(s_in_ch));
        if (s_k_rd_en)
            s_k_data <= k_f(int'(s_k_m), int'(s_k_n), int'(s_k_ch));
    end

    function automatic logic [15:0] model(int r, int c);
        longint acc = 0;
        int pi, pj;
        for (int ch = 0; ch < 2; ch++)
            for (int m = 0; m < 3; m++)
                for (int n = 0; n < 3; n++) begin
                    pi = r + m - 1;
                    pj = c + n - 1;
                    if (pi >= 0 && pi < 4 && pj >= 0 && pj < 4)
                        acc += longint'($signed(in_f(pi, pj, ch))) *
                               longint'($signed(k_f(m, n, ch)));
                end
        acc = acc >>> shift;
        if (relu && acc < 0) acc = 0;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return 16'(acc);
    endfunction

    typedef struct {
        logic [15:0] d;
        int          r;
        int          c;
    } exp_t;

    exp_t q[$];

    task automatic push_layer();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                q.push_back('{model(r, c), r, c});
    endtask

    function automatic logic [63:0] outv();
        return 64'({busy, done, oi.out_valid, in_rd_en, k_rd_en,
                    in_row, in_col, in_ch, k_m, k_n, k_ch,
                    oi.out_data, oi.out_row, oi.out_col});
    endfunction

    task automatic run_layer(input int stall_idx, input int abort_cyc,
                             input bit tim, input bit ign);
        int cyc = 0;
        int nres = 0;
        int ndone = 0;
        int hold = 0;
        int done_cyc = -1;
        bit prev_hs = 0;
        exp_t e;
        logic [15:0] hd;
        logic [3:0]  hp;
        push_layer();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 1000) begin
            cyc++;
            if (cyc == 1) check("busy_rise", 64'(busy), 64'(1));
            if (!in_rd_en)
                check("pad_addr", 64'({in_row, in_col, in_ch, k_m, k_n,
                                       k_ch, k_rd_en}), 64'(0));
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check("abort_rst", outv(), 64'(0));
                check("abort_nres", 64'(nres), 64'(4));
                @(negedge clk);
                rst_n = 1'b1;
                repeat (30) begin
                    @(negedge clk);
                    if (done) ndone++;
                end
                check("abort_done", 64'(ndone), 64'(0));
                check("abort_idle", 64'(busy), 64'(0));
                q.delete();
                return;
            end
            if (prev_hs) check("vld_gap", 64'(oi.out_valid), 64'(0));
            prev_hs = 0;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
                if (tim) check("done_cyc", 64'(cyc), 64'(321));
                check("busy_fall", 64'(busy), 64'(0));
            end
            if (oi.out_valid) begin
                if (nres == 0 && tim) check("lat", 64'(cyc), 64'(20));
                if (nres == stall_idx && hold < 5) begin
                    if (hold == 0) begin
                        hd = oi.out_data;
                        hp = {oi.out_row, oi.out_col};
                    end else begin
                        check("hold_data", 64'(oi.out_data), 64'(hd));
                        check("hold_pos", 64'({oi.out_row, oi.out_col}),
                              64'(hp));
                        check("hold_rd", 64'({in_rd_en, k_rd_en}), 64'(0));
                    end
                    oi.out_ready = 1'b0;
                    hold++;
                end else begin
                    oi.out_ready = 1'b1;
                    if (q.size() == 0) begin
                        check("sb_empty", 64'(1), 64'(0));
                    end else begin
                        e = q.pop_front();
                        check("data", 64'(oi.out_data), 64'(e.d));
                        check("pos", 64'({oi.out_row, oi.out_col}),
                              64'({2'(e.r), 2'(e.c)}));
                    end
                    nres++;
                    prev_hs = 1;
                end
            end else begin
                oi.out_ready = 1'b1;
            end
            start = ign && (cyc == 50 || done);
            if (done_cyc > 0 && cyc > done_cyc)
                check("idle_busy", 64'(busy), 64'(0));
            if (done_cyc > 0 && cyc == done_cyc + 30) break;
            @(negedge clk);
        end
        start = 1'b0;
        check("ndone", 64'(ndone), 64'(1));
        check("nres", 64'(nres), 64'(16));
        check("sb_left", 64'(q.size()), 64'(0));
        q.delete();
    endtask

    initial begin
        int cnt, got;
        bit sdn;
        oi.out_ready = 1'b1;
        so.out_ready = 1'b1;
        #1;
        check("rst", outv(), 64'(0));
        #20;
        rst_n = 1'b1;
        @(negedge clk);

        run_layer(-1, -1, 1, 1);
        run_layer(2, -1, 0, 0);
        run_layer(-1, 85, 0, 0);
        run_layer(-1, -1, 1, 0);

        in_c = 16'h7fff; k_c = 16'h7fff;
        run_layer(-1, -1, 0, 0);
        k_c = 16'h8001;
        run_layer(-1, -1, 0, 0);
        relu = 1'b1;
        run_layer(-1, -1, 0, 0);
        relu = 1'b0; in_c = 16'd16; k_c = 16'd1; shift = 6'd4;
        run_layer(-1, -1, 0, 0);

        mode = 1; shift = 6'd12;
        run_layer(-1, -1, 0, 0);
        shift = 6'd14; relu = 1'b1;
        run_layer(-1, -1, 0, 0);

        mode = 0; in_c = 16'd1; k_c = 16'd1; shift = '0; relu = 1'b0;
        cnt = 0; got = 0; sdn = 0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 1; i < 200; i++) begin
            if (s_in_rd_en) cnt++;
            if (so.out_valid) begin
                check("s_data", 64'(so.out_data), 64'(18));
                check("s_pos", 64'({so.out_row, so.out_col}), 64'(0));
                got++;
            end
            if (s_done) begin
                sdn = 1;
                break;
            end
            @(negedge clk);
        end
        check("s_rd_cnt", 64'(cnt), 64'(18));
        check("s_nres", 64'(got), 64'(1));
        check("s_done", 64'(sdn), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
